// File: rtl/csa_pkg.sv
// csa_pkg: shared state encoding, default guard width and bitwise majority for the carry-save accumulator
package csa_pkg;
  localparam int G_DEF = 8;
  typedef enum logic [1:0] {ACC, RES, HOLD} state_t;
  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/csa_3to2.sv
// csa_3to2: combinational 3:2 compressor producing unshifted partial sum and carry vectors
module csa_3to2
  import csa_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  input  logic [AW-1:0] c,
  output logic [AW-1:0] ps,
  output logic [AW-1:0] sc
);
  assign ps = a ^ b ^ c;
  for (genvar i = 0; i < AW; i++) begin : g_maj
    assign sc[i] = maj(a[i], b[i], c[i]);
  end
endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator: streaming frame accumulator with carry-save running total and one resolve add per frame
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int W = 24,
  parameter int G = G_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [W+G-1:0]   out_sum,
  output logic [G:0]       out_cnt,
  output logic             out_ovf
);
  localparam int AW = W + G;
  localparam logic [G:0] CMAX = {1'b1, {G{1'b0}}};
  state_t state_q, state_d;
  logic [AW-1:0] s_q, s_d, c_q, c_d, x, ps, sc, out_sum_q, out_sum_d;
  logic [G:0] cnt_q, cnt_d, out_cnt_q, out_cnt_d;
  logic ovf_q, ovf_d, out_vld_q, out_vld_d, out_ovf_q, out_ovf_d, beat;
  assign x = {{G{1'b0}}, in_data};
  csa_3to2 #(.AW(AW)) u_csa (.a(s_q), .b(c_q), .c(x), .ps(ps), .sc(sc));
  assign in_rdy = state_q == ACC;
  assign beat = in_vld & in_rdy;
  assign out_vld = out_vld_q;
  assign out_sum = out_sum_q;
  assign out_cnt = out_cnt_q;
  assign out_ovf = out_ovf_q;
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    c_d = c_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    out_vld_d = out_vld_q;
    out_sum_d = out_sum_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      ACC: if (beat) begin
        s_d = ps;
        c_d = sc << 1;
        cnt_d = cnt_q == CMAX ? cnt_q : cnt_q + 1'b1;
        ovf_d = ovf_q | (cnt_q == CMAX);
        state_d = in_last ? RES : ACC;
      end
      RES: begin
        out_sum_d = s_q + c_q;
        out_cnt_d = cnt_q;
        out_ovf_d = ovf_q;
        out_vld_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: if (out_rdy) begin
        out_vld_d = 1'b0;
        s_d = '0;
        c_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
        state_d = ACC;
      end
      default: state_d = ACC;
    endcase
    // abort wins over any beat or handshake; published results stay visible
    if (clr) begin
      state_d = ACC;
      s_d = '0;
      c_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      out_vld_d = 1'b0;
      out_sum_d = out_sum_q;
      out_cnt_d = out_cnt_q;
      out_ovf_d = out_ovf_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      s_q <= '0;
      c_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      out_vld_q <= 1'b0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      out_vld_q <= out_vld_d;
      out_sum_q <= out_sum_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end
endmodule

// File: tb/tb_csa_accumulator.sv
// tb_csa_accumulator: directed and randomized frames checked against an arithmetic frame-sum model
module tb_csa_accumulator;
  logic clk = 0;
  logic rst = 1, clr = 0, in_vld = 0, in_last = 0, out_rdy = 0;
  logic [23:0] in_data = '0;
  logic in_rdy, out_vld, out_ovf;
  logic [31:0] out_sum;
  logic [8:0] out_cnt;
  logic s_clr = 0, s_in_vld = 0, s_in_last = 0, s_out_rdy = 0;
  logic [3:0] s_in_data = '0;
  logic s_in_rdy, s_out_vld, s_out_ovf;
  logic [5:0] s_out_sum;
  logic [2:0] s_out_cnt;
  logic [31:0] exp_sum, prev_sum;
  logic [8:0] exp_cnt;
  logic exp_ovf;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  csa_accumulator #(.W(24), .G(8)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .in_last(in_last), .out_vld(out_vld), .out_rdy(out_rdy), .out_sum(out_sum),
    .out_cnt(out_cnt), .out_ovf(out_ovf));
  csa_accumulator #(.W(4), .G(2)) dut_s (
    .clk(clk), .rst(rst), .clr(s_clr), .in_vld(s_in_vld), .in_rdy(s_in_rdy), .in_data(s_in_data),
    .in_last(s_in_last), .out_vld(s_out_vld), .out_rdy(s_out_rdy), .out_sum(s_out_sum),
    .out_cnt(s_out_cnt), .out_ovf(s_out_ovf));
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", t, o, e);
    end
  endtask
  task automatic frame(input int n, input bit rnd, input logic [23:0] val, input int bub);
    logic [23:0] x;
    logic [31:0] esum;
    esum = '0;
    for (int k = 0; k < n; k++) begin
      x = rnd ? 24'($urandom()) : val;
      while (bub > 0 && $urandom_range(99) < bub) begin
        in_vld = 0;
        @(negedge clk);
      end
      in_vld = 1;
      in_data = x;
      in_last = (k == n - 1);
      esum += {8'd0, x};
      chk("beat_rdy", in_rdy, 1'b1);
      @(negedge clk);
    end
    in_vld = 0;
    in_last = 0;
    exp_sum = esum;
    exp_cnt = n > 256 ? 9'd256 : 9'(n);
    exp_ovf = n > 256;
  endtask
  task automatic get_result(input string tag, input int hold);
    for (int i = 0; i < 4 && !out_vld; i++) @(negedge clk);
    chk({tag, "_vld"}, out_vld, 1'b1);
    repeat (hold) @(negedge clk);
    chk({tag, "_sum"}, out_sum, exp_sum);
    chk({tag, "_cnt"}, out_cnt, exp_cnt);
    chk({tag, "_ovf"}, out_ovf, exp_ovf);
    out_rdy = 1;
    @(negedge clk);
    out_rdy = 0;
    chk({tag, "_vld_drop"}, out_vld, 1'b0);
    chk({tag, "_rdy_back"}, in_rdy, 1'b1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_vld", out_vld, 1'b0);
    chk("rst_sum", out_sum, 32'd0);
    chk("rst_cnt", out_cnt, 9'd0);
    chk("rst_ovf", out_ovf, 1'b0);
    rst = 0;
    chk("rst_rdy", in_rdy, 1'b1);
    frame(1, 0, 24'd5, 0);
    chk("lat_res", out_vld, 1'b0);
    chk("lat_res_rdy", in_rdy, 1'b0);
    @(negedge clk);
    chk("lat_t2", out_vld, 1'b1);
    get_result("single", 0);
    frame(3, 0, 24'hFFFFFF, 0);
    chk("ff3_model", exp_sum, 32'h02FFFFFD);
    in_vld = 1;
    in_data = 24'h10;
    in_last = 1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("hold_rdy", in_rdy, 1'b0);
      chk("hold_vld", out_vld, 1'b1);
      chk("hold_sum", out_sum, 32'h02FFFFFD);
      chk("hold_cnt", out_cnt, 9'd3);
      @(negedge clk);
    end
    out_rdy = 1;
    @(negedge clk);
    out_rdy = 0;
    chk("next_rdy", in_rdy, 1'b1);
    chk("next_vld", out_vld, 1'b0);
    @(negedge clk);
    in_vld = 0;
    in_last = 0;
    exp_sum = 32'h10;
    exp_cnt = 9'd1;
    exp_ovf = 1'b0;
    get_result("after_hold", 0);
    for (int k = 0; k < 5; k++) begin
      s_in_vld = 1;
      s_in_data = 4'hF;
      s_in_last = (k == 4);
      chk("small_rdy", s_in_rdy, 1'b1);
      @(negedge clk);
    end
    s_in_vld = 0;
    s_in_last = 0;
    @(negedge clk);
    chk("small_vld", s_out_vld, 1'b1);
    chk("small_sum", s_out_sum, 6'd11);
    chk("small_cnt", s_out_cnt, 3'd4);
    chk("small_ovf", s_out_ovf, 1'b1);
    s_out_rdy = 1;
    @(negedge clk);
    s_out_rdy = 0;
    chk("small_drop", s_out_vld, 1'b0);
    prev_sum = exp_sum;
    in_vld = 1;
    in_data = 24'd9;
    @(negedge clk);
    in_data = 24'd3;
    @(negedge clk);
    clr = 1;
    in_data = 24'd100;
    in_last = 1;
    @(negedge clk);
    clr = 0;
    in_vld = 0;
    in_last = 0;
    chk("clr_vld", out_vld, 1'b0);
    chk("clr_keep_sum", out_sum, prev_sum);
    chk("clr_rdy", in_rdy, 1'b1);
    frame(1, 0, 24'd7, 0);
    get_result("after_clr", 0);
    for (int f = 0; f < 8; f++) begin
      frame(int'($urandom_range(1, 20)), 1, 24'd0, 30);
      get_result("rand", int'($urandom_range(0, 3)));
    end
    frame(256, 0, 24'hFFFFFF, 0);
    chk("full_model", exp_sum, 32'hFFFFFF00);
    get_result("full256", 1);
    frame(257, 0, 24'hFFFFFF, 0);
    chk("wrap_model", exp_sum, 32'h00FFFEFF);
    get_result("wrap257", 0);
    frame(300, 1, 24'd0, 10);
    get_result("rand_ovf", 2);
    frame(2, 0, 24'd4, 0);
    @(negedge clk);
    chk("pre_rst_vld", out_vld, 1'b1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("hold_rst_vld", out_vld, 1'b0);
    chk("hold_rst_rdy", in_rdy, 1'b1);
    chk("hold_rst_sum", out_sum, 32'd0);
    chk("hold_rst_cnt", out_cnt, 9'd0);
    frame(2, 0, 24'd6, 0);
    get_result("post_rst", 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
